// File: rtl/display_controller_pkg.sv
// Shared constants for the display controller: mode encodings,
// display codes and the LED thermometer helper.
package display_controller_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;
    localparam logic [1:0] ST_QUIT = 2'd3;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [3:0] OVER_CODE    = 4'hE;
    localparam logic [3:0] QUIT_CODE    = 4'h0;

    localparam logic [9:0] LEDR_ALL  = 10'h3FF;
    localparam logic [9:0] LEDR_NONE = 10'h000;

    // Low min(lvl,10) bits set
    function automatic logic [9:0] therm(input logic [3:0] lvl);
        logic [9:0] t;
        t = '0;
        for (int i = 0; i < 10; i++) begin
            if (4'(i) < lvl) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/display_controller_bcd.sv
// Iterative shift-add-3 binary to two-digit BCD converter.
// One load cycle, eight shift cycles; result valid while done is high.
module bcd_converter
    import display_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [7:0] sh;
    logic [7:0] bcd;
    logic [3:0] cnt;
    logic [7:0] adj;
    logic [7:0] bcd_n;

    always_comb begin
        adj = bcd;
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
        bcd_n = {adj[6:0], sh[7]};
    end

    // The final shift result goes straight out so digits update
    // in the same cycle the converter goes idle.
    assign done  = busy && (cnt == 4'd8);
    assign tens  = bcd_n[7:4];
    assign units = bcd_n[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            sh   <= '0;
            bcd  <= '0;
        end else if (!busy) begin
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                sh   <= din;
            end
        end else if (cnt == 4'd0) begin
            bcd <= '0;
            cnt <= 4'd1;
        end else begin
            bcd <= bcd_n;
            sh  <= {sh[6:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd8) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/display_controller.sv
// Game display controller: mode FSM, score-to-BCD latching,
// game-over LED blink and registered 7-seg/LED output muxing.
module display_controller
    import display_controller_pkg::*;
#(
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int SCORE_MAX    = 99
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       userquit,
    input  logic       ingameOn,
    input  logic       gameOver,
    input  logic [7:0] dementiaScore,
    input  logic       score_valid,
    input  logic [3:0] level,
    output logic       score_ready,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
    localparam logic [7:0] SMAX = 8'(SCORE_MAX);

    logic [1:0]    state, state_n;
    logic [CW-1:0] bcnt, bcnt_n;
    logic          bon, bon_n;
    logic [3:0]    dig_t, dig_u, dig_t_n, dig_u_n;
    logic [3:0]    hex0_n, hex4_n, hex5_n;
    logic [9:0]    ledr_n;

    logic       cv_busy, cv_done, cv_start;
    logic [3:0] cv_tens, cv_units;
    logic [7:0] clamped;

    assign score_ready = ~cv_busy;
    assign cv_start    = score_valid && !cv_busy;
    assign clamped     = (dementiaScore > SMAX) ? SMAX : dementiaScore;

    bcd_converter u_bcd (
        .clk   (CLOCK_50),
        .reset (reset),
        .start (cv_start),
        .din   (clamped),
        .busy  (cv_busy),
        .done  (cv_done),
        .tens  (cv_tens),
        .units (cv_units)
    );

    always_comb begin
        state_n = state;
        if (userquit || state == ST_QUIT) begin
            state_n = ST_QUIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gameOver)      state_n = ST_OVER;
                    else if (ingameOn) state_n = ST_PLAY;
                end
                ST_PLAY: begin
                    if (gameOver)       state_n = ST_OVER;
                    else if (!ingameOn) state_n = ST_IDLE;
                end
                ST_OVER: begin
                    if (!gameOver && !ingameOn) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Blink restarts lit on every OVER entry
    always_comb begin
        bcnt_n = '0;
        bon_n  = 1'b0;
        if (state_n == ST_OVER) begin
            if (state != ST_OVER) begin
                bon_n = 1'b1;
            end else if (bcnt == BLINK_LAST) begin
                bon_n = ~bon;
            end else begin
                bcnt_n = bcnt + 1'b1;
                bon_n  = bon;
            end
        end
    end

    always_comb begin
        dig_t_n = cv_done ? cv_tens  : dig_t;
        dig_u_n = cv_done ? cv_units : dig_u;
        hex0_n  = BLANK_NIBBLE;
        hex4_n  = dig_u_n;
        hex5_n  = (dig_t_n == 4'd0) ? BLANK_NIBBLE : dig_t_n;
        ledr_n  = LEDR_NONE;
        case (state_n)
            ST_IDLE: begin
                hex4_n = BLANK_NIBBLE;
                hex5_n = BLANK_NIBBLE;
            end
            ST_PLAY: begin
                hex0_n = level;
                ledr_n = therm(level);
            end
            ST_OVER: begin
                hex0_n = OVER_CODE;
                ledr_n = bon_n ? LEDR_ALL : LEDR_NONE;
            end
            default: hex0_n = QUIT_CODE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= ST_IDLE;
            bcnt     <= '0;
            bon      <= 1'b0;
            dig_t    <= '0;
            dig_u    <= '0;
            hex0hldr <= BLANK_NIBBLE;
            hex4hldr <= BLANK_NIBBLE;
            hex5hldr <= BLANK_NIBBLE;
            ledrhldr <= LEDR_NONE;
        end else begin
            state    <= state_n;
            bcnt     <= bcnt_n;
            bon      <= bon_n;
            dig_t    <= dig_t_n;
            dig_u    <= dig_u_n;
            hex0hldr <= hex0_n;
            hex4hldr <= hex4_n;
            hex5hldr <= hex5_n;
            ledrhldr <= ledr_n;
        end
    end

endmodule

// File: tb/tb_display_controller.sv
// Directed self-checking bench for display_controller.
// Short blink half-period so the game-over pattern is observable.
module tb_display_controller;

    logic       clk = 1'b0;
    logic       reset, userquit, ingameOn, gameOver;
    logic [7:0] score;
    logic       score_valid;
    logic [3:0] level;
    logic       score_ready;
    logic [3:0] hex0, hex4, hex5;
    logic [9:0] ledr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display_controller #(.BLINK_CYCLES(4), .SCORE_MAX(99)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .userquit      (userquit),
        .ingameOn      (ingameOn),
        .gameOver      (gameOver),
        .dementiaScore (score),
        .score_valid   (score_valid),
        .level         (level),
        .score_ready   (score_ready),
        .hex0hldr      (hex0),
        .hex4hldr      (hex4),
        .hex5hldr      (hex5),
        .ledrhldr      (ledr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " hex0"}, 10'(hex0), 10'hF);
        chk({tag, " hex4"}, 10'(hex4), 10'hF);
        chk({tag, " hex5"}, 10'(hex5), 10'hF);
        chk({tag, " ledr"}, ledr, 10'h000);
        chk({tag, " ready"}, 10'(score_ready), 10'h1);
    endtask

    task automatic convert(input logic [7:0] v);
        score       = v;
        score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        repeat (9) tick();
    endtask

    logic [9:0] blink_exp [9] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                                  10'h000, 10'h000, 10'h000, 10'h000,
                                  10'h3FF};

    initial begin
        reset = 1'b1; userquit = 1'b0; ingameOn = 1'b0; gameOver = 1'b0;
        score = '0; score_valid = 1'b0; level = '0;
        tick();
        tick();
        chk_reset_vals("reset");

        // enter PLAY at level 3
        reset = 1'b0; ingameOn = 1'b1; level = 4'd3;
        tick();
        chk("play hex0", 10'(hex0), 10'h3);
        chk("play ledr", ledr, 10'h007);
        chk("play hex5", 10'(hex5), 10'hF);
        chk("play hex4", 10'(hex4), 10'h0);

        // conversion of 47 with an ignored pulse of 12 at cycle 3
        score = 8'd47; score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        chk("c47 ready c0", 10'(score_ready), 10'h0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                score = 8'd12; score_valid = 1'b1;
            end
            tick();
            score_valid = 1'b0;
            if (k < 9) begin
                chk($sformatf("c47 ready c%0d", k), 10'(score_ready), 10'h0);
                chk($sformatf("c47 hex4 c%0d", k), 10'(hex4), 10'h0);
                chk($sformatf("c47 hex5 c%0d", k), 10'(hex5), 10'hF);
            end else begin
                chk("c47 ready done", 10'(score_ready), 10'h1);
                chk("c47 hex5", 10'(hex5), 10'h4);
                chk("c47 hex4", 10'(hex4), 10'h7);
            end
        end
        tick();
        chk("c47 no requeue hex4", 10'(hex4), 10'h7);
        chk("c47 no requeue ready", 10'(score_ready), 10'h1);

        convert(8'd200);
        chk("c200 hex5", 10'(hex5), 10'h9);
        chk("c200 hex4", 10'(hex4), 10'h9);
        convert(8'd5);
        chk("c5 hex5", 10'(hex5), 10'hF);
        chk("c5 hex4", 10'(hex4), 10'h5);

        level = 4'd12;
        tick();
        chk("lvl12 hex0", 10'(hex0), 10'hC);
        chk("lvl12 ledr", ledr, 10'h3FF);

        ingameOn = 1'b0;
        tick();
        chk("idle hex0", 10'(hex0), 10'hF);
        chk("idle hex4", 10'(hex4), 10'hF);
        chk("idle ledr", ledr, 10'h000);

        // game over blink, half-period 4
        gameOver = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("blink %0d", i), ledr, blink_exp[i]);
            if (i == 0) begin
                chk("over hex0", 10'(hex0), 10'hE);
                chk("over hex4", 10'(hex4), 10'h5);
                chk("over hex5", 10'(hex5), 10'hF);
            end
        end

        userquit = 1'b1;
        tick();
        chk("quit hex0", 10'(hex0), 10'h0);
        chk("quit ledr", ledr, 10'h000);
        chk("quit hex4", 10'(hex4), 10'h5);
        userquit = 1'b0; gameOver = 1'b0; ingameOn = 1'b1;
        tick();
        tick();
        chk("quit sticky hex0", 10'(hex0), 10'h0);
        chk("quit sticky ledr", ledr, 10'h000);

        // reset four cycles into a conversion of 63
        reset = 1'b1;
        tick();
        reset = 1'b0; level = 4'd2;
        tick();
        chk("replay hex0", 10'(hex0), 10'h2);
        score = 8'd63; score_valid = 1'b1;
        tick();
        score_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("abort");
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("abort hex4 %0d", k), 10'(hex4), 10'h0);
            chk($sformatf("abort hex5 %0d", k), 10'(hex5), 10'hF);
        end
        chk("abort ready", 10'(score_ready), 10'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
